miriscv_apb_bridge: RTL and testbench
=====================================

Name: miriscv_apb_bridge

Overview:
- Bridges the core data-memory request interface (req/we/be/addr/wdata, rvalid/rdata) to an APB4 bus with two slaves: UART (slave 0) and timer (slave 1).
- Sits between the SoC top-level address decode (which routes addr[31]=1 traffic here) and the apb_uart / apb_timer instances.
- Replaces the fixed one-cycle response with proper SETUP/ACCESS phasing, PREADY wait states, PSLVERR reporting and a bus timeout.

Parameters:
- SEL_BIT, 12, address bit selecting the slave (0 = UART, 1 = timer).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles without PREADY before forced error completion; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, rdata_o value returned on timeout.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  core request, already gated by SoC decode.
- we_i  in  1  write enable.
- be_i  in  XLEN/8  byte enables.
- addr_i  in  XLEN  address.
- wdata_i  in  XLEN  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  one-cycle completion pulse, for reads and writes.
- rdata_o  out  XLEN  read data, valid with rvalid_o.
- err_o  out  1  completion carried PSLVERR or timeout; valid with rvalid_o.
- paddr_o  out  XLEN  APB address.
- psel_o  out  2  one-hot slave select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB write.
- pwdata_o  out  XLEN  APB write data.
- pstrb_o  out  XLEN/8  APB strobes.
- prdata0_i / prdata1_i  in  XLEN  slave read data.
- pready0_i / pready1_i  in  1  slave ready.
- pslverr0_i / pslverr1_i  in  1  slave error.

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP.
- Reset (async, arstn_i=0): state=IDLE. psel_o=0, penable_o=0, pwrite_o=0, rvalid_o=0, err_o=0, gnt_o=0. paddr_o, pwdata_o, pstrb_o and rdata_o are all 0. Timeout counter=0.
- Reset asserted mid-transfer aborts immediately: no rvalid_o is issued, and psel_o drops asynchronously.
- IDLE:
  - gnt_o = req_i (combinational). gnt_o is 0 in every other state.
  - On req_i=1, register addr_i, we_i and wdata_i. Register pstrb = we_i ? be_i : 0 (reads always drive PSTRB=0).
  - Register slave index = addr_i[SEL_BIT], then go to SETUP.
- SETUP (exactly one cycle): psel_o[idx]=1, penable_o=0, then go to ACCESS.
- ACCESS: psel_o[idx]=1 and penable_o=1.
  - When the selected pready is 1: latch rdata = we ? 0 : selected prdata, and err = selected pslverr. Go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES (if nonzero): latch rdata=ERR_DATA, err=1, and go to RESP.
  - The unselected slave's pready, pslverr and prdata are ignored.
- RESP (one cycle):
  - psel_o=0 and penable_o=0.
  - rvalid_o=1, with rdata_o and err_o driven from registers.
  - Counter clears; go to IDLE.
- APB outputs stay stable from SETUP through the end of ACCESS.
- Latency: gnt in cycle N gives SETUP at N+1, ACCESS at N+2, and rvalid_o at N+3 with zero wait states. Each PREADY wait cycle adds 1.
- Throughput is at most one transfer per 4 cycles. req_i is ignored outside IDLE; the core holds req_i until rvalid_o.
- rdata_o holds its last value between completions. rvalid_o and err_o are registered.
- be_i=0 on a write is still issued, with PSTRB=0.
- Address bits other than SEL_BIT are passed to paddr_o unmodified; slaves slice them as needed.
- A timeout with the slave asserting PREADY in the same cycle as the counter hit completes as a normal (PREADY) response.

Decomposition:
- In miriscv_pkg: XLEN (existing), typedef enum logic [1:0] apb_bridge_state_t {IDLE, SETUP, ACCESS, RESP}, and constant APB_ERR_DATA.
- No sub-module required. The timeout counter is inline, with width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Zero-wait read:
  - Stimulus: req at addr 32'h8000_0004, timer idle, pready0=1, prdata0=32'h0000_0060.
  - Response: psel_o=2'b01 in cycles N+1..N+2, penable_o only at N+2, rvalid_o at N+3, rdata_o=32'h60, err_o=0.
- Wait-state write:
  - Stimulus: write 32'hA5A5_0001, be=4'b0011 to 32'h8000_1008; pready1 held low for 3 ACCESS cycles.
  - Response: psel_o=2'b10, pwrite_o=1, pstrb_o=4'b0011 stable throughout, rvalid_o at N+6, rdata_o=0.
- Slave error:
  - Stimulus: read to UART with pready0=1, pslverr0=1, prdata0=32'h1234.
  - Response: rvalid_o with err_o=1 and rdata_o=32'h1234.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, timer read with pready1 stuck at 0.
  - Response: rvalid_o 3+4 cycles after gnt, rdata_o=32'hDEAD_BEEF, err_o=1, psel_o=0 in the RESP cycle.
- Busy / back-to-back:
  - Stimulus: req_i held high continuously.
  - Response: gnt_o pulses exactly once per 4 cycles (zero-wait); req_i changes outside IDLE do not alter paddr_o.
- Async reset:
  - Stimulus: assert arstn_i=0 during ACCESS.
  - Response: psel_o and penable_o drop with no clock edge, no rvalid_o, state IDLE after release; next request completes normally.

Source files
------------

// File: rtl/miriscv_pkg.sv
// Shared constants and types for the miriscv core and its peripheral bridge.
package miriscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_bridge_state_t;

  localparam logic [XLEN-1:0] APB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/miriscv_apb_bridge.sv
// Core data-memory request port to APB4 bridge for two slaves (0 = UART, 1 = timer).
// Handles SETUP/ACCESS phasing, PREADY wait states, PSLVERR and a bus timeout.
module miriscv_apb_bridge
  import miriscv_pkg::*;
#(
  parameter int              SEL_BIT        = 12,
  parameter int              TIMEOUT_CYCLES = 256,
  parameter logic [XLEN-1:0] ERR_DATA       = APB_ERR_DATA
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              req_i,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              err_o,

  output logic [XLEN-1:0]   paddr_o,
  output logic [1:0]        psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [XLEN-1:0]   pwdata_o,
  output logic [XLEN/8-1:0] pstrb_o,
  input  logic [XLEN-1:0]   prdata0_i,
  input  logic [XLEN-1:0]   prdata1_i,
  input  logic              pready0_i,
  input  logic              pready1_i,
  input  logic              pslverr0_i,
  input  logic              pslverr1_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  apb_bridge_state_t r_state;
  apb_bridge_state_t w_state_next;

  logic              r_sel;
  logic [XLEN-1:0]   r_paddr;
  logic              r_pwrite;
  logic [XLEN-1:0]   r_pwdata;
  logic [XLEN/8-1:0] r_pstrb;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic              r_rvalid;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_pready;
  logic              w_pslverr;
  logic [XLEN-1:0]   w_prdata;
  logic              w_timeout;
  logic              w_bus_active;

  // Only the selected slave's response is observed; the other is ignored.
  assign w_pready  = r_sel ? pready1_i  : pready0_i;
  assign w_pslverr = r_sel ? pslverr1_i : pslverr0_i;
  assign w_prdata  = r_sel ? prdata1_i  : prdata0_i;

  // A slave raising PREADY in the same cycle wins over the timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX);

  // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_i) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_pready || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_sel    <= 1'b0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (gnt_o) begin
      r_sel    <= addr_i[SEL_BIT];
      r_paddr  <= addr_i;
      r_pwrite <= we_i;
      r_pwdata <= wdata_i;
      r_pstrb  <= we_i ? be_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (r_state == ACCESS) begin
        if (w_pready) begin
          r_rdata  <= r_pwrite ? '0 : w_prdata;
          r_err    <= w_pslverr;
          r_rvalid <= 1'b1;
        end else if (w_timeout) begin
          r_rdata  <= ERR_DATA;
          r_err    <= 1'b1;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_cnt <= '0;
    end else if (r_state == RESP) begin
      r_cnt <= '0;
    end else if ((r_state == ACCESS) && !w_pready && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // PSEL/PENABLE decode straight from the state flop so reset drops them without a clock.
  assign w_bus_active = (r_state == SETUP) || (r_state == ACCESS);

  assign gnt_o     = (r_state == IDLE) && req_i;
  assign psel_o    = w_bus_active ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign penable_o = (r_state == ACCESS);
  assign paddr_o   = r_paddr;
  assign pwrite_o  = r_pwrite;
  assign pwdata_o  = r_pwdata;
  assign pstrb_o   = r_pstrb;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;

endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// Directed self-checking bench for miriscv_apb_bridge (timeout shortened to 4 cycles).
module tb_miriscv_apb_bridge;
  import miriscv_pkg::*;

  logic              clk_i;
  logic              arstn_i;
  logic              req_i;
  logic              we_i;
  logic [XLEN/8-1:0] be_i;
  logic [XLEN-1:0]   addr_i;
  logic [XLEN-1:0]   wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [XLEN-1:0]   rdata_o;
  logic              err_o;
  logic [XLEN-1:0]   paddr_o;
  logic [1:0]        psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [XLEN-1:0]   pwdata_o;
  logic [XLEN/8-1:0] pstrb_o;
  logic [XLEN-1:0]   prdata0_i;
  logic [XLEN-1:0]   prdata1_i;
  logic              pready0_i;
  logic              pready1_i;
  logic              pslverr0_i;
  logic              pslverr1_i;

  int n_vec = 0;
  int n_err = 0;

  miriscv_apb_bridge #(
    .SEL_BIT        (12),
    .TIMEOUT_CYCLES (4),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .paddr_o    (paddr_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .prdata0_i  (prdata0_i),
    .prdata1_i  (prdata1_i),
    .pready0_i  (pready0_i),
    .pready1_i  (pready1_i),
    .pslverr0_i (pslverr0_i),
    .pslverr1_i (pslverr1_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic drive_slave(input logic idx, input logic rdy, input logic err,
                             input logic [31:0] d);
    if (idx) begin
      pready1_i = rdy; pslverr1_i = err; prdata1_i = d;
    end else begin
      pready0_i = rdy; pslverr0_i = err; prdata0_i = d;
    end
  endtask

  // One transfer: selected slave holds PREADY low for n_wait ACCESS cycles
  // (n_wait >= 99 means never ready); the other slave is kept noisy to prove it is ignored.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int n_wait,
                      input logic slverr, input logic [31:0] prdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic       sel;
    logic [1:0] exp_psel;
    logic [3:0] exp_strb;
    bit         done;
    sel      = addr[12];
    exp_psel = sel ? 2'b10 : 2'b01;
    exp_strb = we ? be : 4'h0;
    done     = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    drive_slave(sel, 1'b0, slverr, prdata);
    drive_slave(!sel, 1'b1, 1'b1, 32'hBAD0_BAD0);
    @(negedge clk_i);
    check({tag, ".gnt"}, 96'(gnt_o), 96'(1'b1));
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_i); #1;
      drive_slave(sel, (c >= 2) && (c - 2 >= n_wait), slverr, prdata);
      @(negedge clk_i);
      if (rvalid_o) begin
        done = 1'b1;
        check({tag, ".lat"}, 96'(c), 96'(exp_lat));
        check({tag, ".rdata"}, 96'(rdata_o), 96'(exp_rdata));
        check({tag, ".err"}, 96'(err_o), 96'(exp_err));
        check({tag, ".resp_bus"}, 96'({gnt_o, psel_o, penable_o}), 96'(0));
        break;
      end
      check({tag, ".phase"},
            96'({gnt_o, psel_o, penable_o, pwrite_o, pstrb_o, paddr_o, pwdata_o}),
            96'({1'b0, exp_psel, (c >= 2), we, exp_strb, addr, wdata}));
    end
    if (!done) check({tag, ".no_rvalid"}, 96'(0), 96'(1));
    @(posedge clk_i); #1;
    req_i = 1'b0;
    drive_slave(1'b0, 1'b0, 1'b0, 32'h0);
    drive_slave(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check({tag, ".hold"}, 96'({rvalid_o, rdata_o}), 96'({1'b0, exp_rdata}));
  endtask

  initial begin
    logic [31:0] exp_paddr;
    int          gcount;
    arstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
    prdata0_i = '0; prdata1_i = '0; pready0_i = 1'b0; pready1_i = 1'b0;
    pslverr0_i = 1'b0; pslverr1_i = 1'b0;
    #1;
    check("reset.ctrl", 96'({psel_o, penable_o, pwrite_o, rvalid_o, err_o, gnt_o}), 96'(0));
    check("reset.data", 96'({paddr_o, pwdata_o, pstrb_o}), 96'(0));
    check("reset.rdata", 96'(rdata_o), 96'(0));
    repeat (2) @(posedge clk_i);
    #2 arstn_i = 1'b1;

    //    tag      we    addr           wdata          be       wait slverr prdata         exp_rdata      err  lat
    xfer("rd0",   1'b0, 32'h8000_0004, 32'h0,         4'hF,    0,   1'b0,  32'h0000_0060, 32'h0000_0060, 1'b0, 3);
    xfer("wr3",   1'b1, 32'h8000_1008, 32'hA5A5_0001, 4'b0011, 3,   1'b0,  32'hFFFF_FFFF, 32'h0,         1'b0, 6);
    xfer("serr",  1'b0, 32'h8000_0010, 32'h0,         4'h0,    0,   1'b1,  32'h0000_1234, 32'h0000_1234, 1'b1, 3);
    xfer("tmo",   1'b0, 32'h8000_1000, 32'h0,         4'h0,    99,  1'b0,  32'h0000_5555, 32'hDEAD_BEEF, 1'b1, 7);
    xfer("hit",   1'b0, 32'h8000_1004, 32'h0,         4'h0,    4,   1'b0,  32'h7777_0000, 32'h7777_0000, 1'b0, 7);
    xfer("wrbe0", 1'b1, 32'h8000_0020, 32'h1111_2222, 4'h0,    0,   1'b0,  32'h0000_0099, 32'h0,         1'b0, 3);
    xfer("wrerr", 1'b1, 32'h8000_100C, 32'h0000_CAFE, 4'hF,    1,   1'b1,  32'h0000_0099, 32'h0,         1'b1, 4);

    // Back-to-back: req held high, address wiggles every cycle.
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; be_i = '0;
    pready0_i = 1'b1; pslverr0_i = 1'b0; prdata0_i = 32'h0000_00AA;
    exp_paddr = '0;
    gcount = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk_i); #1;
      end
      addr_i = 32'h8000_0000 + 32'(i * 16);
      @(negedge clk_i);
      if (gnt_o) begin
        gcount++;
        exp_paddr = addr_i;
      end
      if (psel_o != 2'b00) check("b2b.paddr", 96'(paddr_o), 96'(exp_paddr));
    end
    check("b2b.gnt_count", 96'(gcount), 96'(4));
    @(posedge clk_i); #1;
    req_i = 1'b0; pready0_i = 1'b0;

    // Asynchronous reset in the middle of ACCESS.
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8000_1040; pready1_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst.pre", 96'({psel_o, penable_o}), 96'({2'b10, 1'b1}));
    #2 arstn_i = 1'b0;
    req_i = 1'b0;
    #1;
    check("rst.async", 96'({psel_o, penable_o, rvalid_o}), 96'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst.no_rvalid", 96'(rvalid_o), 96'(0));
    end
    @(posedge clk_i); #2;
    arstn_i = 1'b1;
    @(negedge clk_i);
    check("rst.idle", 96'({psel_o, penable_o, rvalid_o, gnt_o, paddr_o}), 96'(0));
    xfer("post",  1'b0, 32'h8000_1000, 32'h0,         4'h0,    0,   1'b0,  32'h0000_0042, 32'h0000_0042, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
